// File: rtl/l2cache_lookup_ctrl_if.sv
// rtl/l2cache_lookup_ctrl_if.sv - L1-miss, compare, SRAM-update and memory ports of the L2 lookup controller
interface l2cache_lookup_ctrl_if #(
  parameter int TAG_W = 19,
  parameter int IDX_W = 9
);
  logic             req_valid;
  logic             req_ready;
  logic [33:0]      req_pa;
  logic             req_write;
  logic             sram_rd_en;
  logic [IDX_W-1:0] sram_idx;
  logic [TAG_W-1:0] cmp_tag;
  logic             cmp_hit;
  logic             cmp_need_wb;
  logic             cmp_have_empty;
  logic [2:0]       cmp_hit_way;
  logic [2:0]       cmp_empty_way;
  logic [2:0]       cmp_evict_way;
  logic [6:0]       plru_in;
  logic             plru_we;
  logic [6:0]       plru_out;
  logic             tagdv_we;
  logic [2:0]       tagdv_way;
  logic [TAG_W-1:0] tagdv_tag;
  logic [1:0]       tagdv_dv;
  logic             wb_valid;
  logic             wb_ready;
  logic [2:0]       wb_way;
  logic             rf_valid;
  logic             rf_ready;
  logic             rf_done;
  logic             resp_valid;
  logic             resp_hit;

  modport master (
    output req_valid, req_pa, req_write,
    output cmp_hit, cmp_need_wb, cmp_have_empty, cmp_hit_way, cmp_empty_way, cmp_evict_way,
    output plru_in, wb_ready, rf_ready, rf_done,
    input  req_ready, sram_rd_en, sram_idx, cmp_tag, plru_we, plru_out,
    input  tagdv_we, tagdv_way, tagdv_tag, tagdv_dv, wb_valid, wb_way, rf_valid,
    input  resp_valid, resp_hit
  );

  modport slave (
    input  req_valid, req_pa, req_write,
    input  cmp_hit, cmp_need_wb, cmp_have_empty, cmp_hit_way, cmp_empty_way, cmp_evict_way,
    input  plru_in, wb_ready, rf_ready, rf_done,
    output req_ready, sram_rd_en, sram_idx, cmp_tag, plru_we, plru_out,
    output tagdv_we, tagdv_way, tagdv_tag, tagdv_dv, wb_valid, wb_way, rf_valid,
    output resp_valid, resp_hit
  );
endinterface

// File: rtl/l2cache_lookup_ctrl.sv
// rtl/l2cache_lookup_ctrl.sv - blocking L2 access sequencer: tag read, compare, writeback/refill, tag/PLRU update
// Optional L2_PERF_CNT_EN adds saturating hit/miss/writeback counters.
module l2cache_lookup_ctrl #(
  parameter int TAG_W = 19,
  parameter int IDX_W = 9,
  parameter int WAYS  = 8
) (
  input  logic clk,
  input  logic rst,
  l2cache_lookup_ctrl_if.slave bus
`ifdef L2_PERF_CNT_EN
  ,
  output logic [31:0] perf_hit_cnt,
  output logic [31:0] perf_miss_cnt,
  output logic [31:0] perf_wb_cnt
`endif
);
  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_CMP, S_WB, S_RF_REQ, S_RF_WAIT, S_UPD, S_RESP
  } state_e;

  state_e           state_q, state_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             write_q, write_d;
  logic             hit_q, hit_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [6:0]       plru_q, plru_d;
  logic             unused_pa_lsbs;

  assign unused_pa_lsbs = ^bus.req_pa[5:0];

  // Point every tree bit on the path to w away from w; other bits are preserved.
  function automatic logic [6:0] plru_next(input logic [6:0] p, input logic [2:0] w);
    logic [6:0] n;
    n    = p;
    n[0] = ~w[2];
    if (w[2]) n[2] = ~w[1];
    else      n[1] = ~w[1];
    case (w[2:1])
      2'd0:    n[3] = ~w[0];
      2'd1:    n[4] = ~w[0];
      2'd2:    n[5] = ~w[0];
      default: n[6] = ~w[0];
    endcase
    return n;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      write_q  <= 1'b0;
      hit_q    <= 1'b0;
      victim_q <= '0;
      plru_q   <= '0;
    end else begin
      state_q  <= state_d;
      tag_q    <= tag_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      hit_q    <= hit_d;
      victim_q <= victim_d;
      plru_q   <= plru_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tag_d    = tag_q;
    idx_d    = idx_q;
    write_d  = write_q;
    hit_d    = hit_q;
    victim_d = victim_q;
    plru_d   = plru_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          tag_d   = bus.req_pa[6+IDX_W +: TAG_W];
          idx_d   = bus.req_pa[6 +: IDX_W];
          write_d = bus.req_write;
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_CMP;
      S_CMP: begin
        hit_d    = bus.cmp_hit;
        plru_d   = bus.plru_in;
        victim_d = bus.cmp_hit        ? bus.cmp_hit_way :
                   bus.cmp_have_empty ? bus.cmp_empty_way : bus.cmp_evict_way;
        if (bus.cmp_hit)          state_d = S_UPD;
        else if (bus.cmp_need_wb) state_d = S_WB;
        else                      state_d = S_RF_REQ;
      end
      S_WB:      if (bus.wb_ready) state_d = S_RF_REQ;
      S_RF_REQ:  if (bus.rf_ready) state_d = S_RF_WAIT;
      S_RF_WAIT: if (bus.rf_done)  state_d = S_UPD;
      S_UPD:     state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == S_IDLE);
    bus.sram_rd_en = (state_q == S_READ);
    bus.sram_idx   = idx_q;
    bus.cmp_tag    = tag_q;
    bus.wb_valid   = (state_q == S_WB);
    bus.wb_way     = (state_q == S_WB) ? victim_q : '0;
    bus.rf_valid   = (state_q == S_RF_REQ);
    bus.plru_we    = (state_q == S_UPD);
    bus.plru_out   = (state_q == S_UPD) ? plru_next(plru_q, victim_q) : 7'h00;
    // A clean hit leaves tag/dv alone; any miss or store rewrites it with dv={write,1}.
    bus.tagdv_we   = (state_q == S_UPD) && (!hit_q || write_q);
    bus.tagdv_way  = bus.tagdv_we ? victim_q : '0;
    bus.tagdv_tag  = bus.tagdv_we ? tag_q : '0;
    bus.tagdv_dv   = bus.tagdv_we ? {write_q, 1'b1} : 2'b00;
    bus.resp_valid = (state_q == S_RESP);
    bus.resp_hit   = (state_q == S_RESP) && hit_q;
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d, wb_cnt_q, wb_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    wb_cnt_d   = wb_cnt_q;
    if (state_q == S_RESP && hit_q && hit_cnt_q != 32'hFFFF_FFFF)
      hit_cnt_d = hit_cnt_q + 32'd1;
    if (state_q == S_RESP && !hit_q && miss_cnt_q != 32'hFFFF_FFFF)
      miss_cnt_d = miss_cnt_q + 32'd1;
    if (state_q == S_WB && bus.wb_ready && wb_cnt_q != 32'hFFFF_FFFF)
      wb_cnt_d = wb_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      wb_cnt_q   <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      wb_cnt_q   <= wb_cnt_d;
    end
  end

  assign perf_hit_cnt  = hit_cnt_q;
  assign perf_miss_cnt = miss_cnt_q;
  assign perf_wb_cnt   = wb_cnt_q;
`endif
endmodule
